// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundles the per-master Wishbone request ports (packed,
// port i at slice i) and the single controller-side Wishbone port.
// The 'slave' modport is the arbiter's view.
// The 'master' modport is the view of the environment, which holds the
// requesting masters plus the SDRAM controller.
interface wb_port_arbiter_if #(
  parameter int NR_OF_PORTS = 3,
  parameter int ADR_W       = 30
);
  // master -> arbiter request side
  logic [NR_OF_PORTS-1:0]       wbs_cyc_i;
  logic [NR_OF_PORTS-1:0]       wbs_stb_i;
  logic [NR_OF_PORTS-1:0]       wbs_we_i;
  logic [NR_OF_PORTS*ADR_W-1:0] wbs_adr_i;
  logic [NR_OF_PORTS*32-1:0]    wbs_dat_i;
  logic [NR_OF_PORTS*4-1:0]     wbs_sel_i;
  logic [NR_OF_PORTS*3-1:0]     wbs_cti_i;
  logic [NR_OF_PORTS*2-1:0]     wbs_bte_i;
  logic [31:0]                  wbs_dat_o;
  logic [NR_OF_PORTS-1:0]       wbs_ack_o;
  // arbiter -> controller side
  logic                         wbm_cyc_o;
  logic                         wbm_stb_o;
  logic                         wbm_we_o;
  logic [ADR_W-1:0]             wbm_adr_o;
  logic [31:0]                  wbm_dat_o;
  logic [3:0]                   wbm_sel_o;
  logic [2:0]                   wbm_cti_o;
  logic [1:0]                   wbm_bte_o;
  logic [31:0]                  wbm_dat_i;
  logic                         wbm_ack_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
           wbs_sel_i, wbs_cti_i, wbs_bte_i, wbm_dat_i, wbm_ack_i,
    output wbs_dat_o, wbs_ack_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
           wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
           wbs_sel_i, wbs_cti_i, wbs_bte_i, wbm_dat_i, wbm_ack_i,
    input  wbs_dat_o, wbs_ack_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
           wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the SDRAM controller's single Wishbone slave port
// among NR_OF_PORTS masters.
// Grant is round-robin and is held for the owner's whole cyc tenure, so
// bursts are never split.
// Between two tenures there is always one idle cycle, which lets the
// controller see cyc drop.
// Optional macro WB_ARB_PREEMPT_EN: releases a tenure after MAX_XFERS
// completed transfers when another master is waiting. The release never
// happens in the middle of a burst.
module wb_port_arbiter #(
  parameter int NR_OF_PORTS = 3,
  parameter int ADR_W       = 30,
  parameter int MAX_XFERS   = 4
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  wb_port_arbiter_if.slave       bus,
  output logic [NR_OF_PORTS-1:0] grant_o
);
  localparam int IDX_W = $clog2(NR_OF_PORTS);

  typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last;
  logic [NR_OF_PORTS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   owner_cyc;
  logic                   preempt;
  logic                   mux_we;
  logic [ADR_W-1:0]       mux_adr;
  logic [31:0]            mux_dat;
  logic [3:0]             mux_sel;
  logic [2:0]             mux_cti;
  logic [1:0]             mux_bte;

  if ((NR_OF_PORTS < 2) || (NR_OF_PORTS > 8) || (MAX_XFERS < 1)) begin : g_param_check
    $error("wb_port_arbiter: NR_OF_PORTS must be 2..8 and MAX_XFERS at least 1");
  end

  // Round-robin search: first cyc requester above the last-served port, wrapping
  always_comb begin : rr_search
    logic             found;
    logic             take;
    logic [IDX_W-1:0] pidx;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    take     = 1'b0;
    pidx     = '0;
    for (int k = 1; k <= NR_OF_PORTS; k++) begin
      pidx       = IDX_W'((int'(last) + k) % NR_OF_PORTS);
      take       = bus.wbs_cyc_i[pidx] & ~found;
      pick[pidx] = take;
      pick_idx   = take ? pidx : pick_idx;
      found      = found | take;
    end
  end

  // Select the granted master's request fields; everything is zero while idle
  always_comb begin
    mux_we  = 1'b0;
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    mux_cti = '0;
    mux_bte = '0;
    for (int i = 0; i < NR_OF_PORTS; i++) begin
      mux_we  = mux_we  | (bus.wbs_we_i[i] & grant_o[i]);
      mux_adr = mux_adr | (bus.wbs_adr_i[i*ADR_W +: ADR_W] & {ADR_W{grant_o[i]}});
      mux_dat = mux_dat | (bus.wbs_dat_i[i*32 +: 32] & {32{grant_o[i]}});
      mux_sel = mux_sel | (bus.wbs_sel_i[i*4 +: 4] & {4{grant_o[i]}});
      mux_cti = mux_cti | (bus.wbs_cti_i[i*3 +: 3] & {3{grant_o[i]}});
      mux_bte = mux_bte | (bus.wbs_bte_i[i*2 +: 2] & {2{grant_o[i]}});
    end
    owner_cyc = |(bus.wbs_cyc_i & grant_o);
  end

  // Drive the controller port; ack goes only to the owner, read data to all
  always_comb begin
    bus.wbm_cyc_o = owner_cyc;
    bus.wbm_stb_o = |(bus.wbs_stb_i & grant_o);
    bus.wbm_we_o  = mux_we;
    bus.wbm_adr_o = mux_adr;
    bus.wbm_dat_o = mux_dat;
    bus.wbm_sel_o = mux_sel;
    bus.wbm_cti_o = mux_cti;
    bus.wbm_bte_o = mux_bte;
    bus.wbs_ack_o = grant_o & {NR_OF_PORTS{bus.wbm_ack_i}};
    bus.wbs_dat_o = bus.wbm_dat_i;
  end

`ifdef WB_ARB_PREEMPT_EN
  localparam int CNT_W = $clog2(MAX_XFERS + 1);

  logic [CNT_W-1:0] xfers;
  logic [CNT_W-1:0] xfers_next;
  logic             burst_open;
  logic             burst_open_next;
  logic             beat_ack;
  logic             end_ack;
  logic             others_waiting;

  // Count completed transfers (classic or end-of-burst) and track open bursts
  always_comb begin
    beat_ack       = bus.wbm_ack_i & (state == OWNED);
    end_ack        = beat_ack & ((mux_cti == 3'b000) | (mux_cti == 3'b111));
    others_waiting = |(bus.wbs_cyc_i & ~grant_o);
    if (end_ack && (xfers < CNT_W'(MAX_XFERS))) begin
      xfers_next = xfers + CNT_W'(1);
    end else begin
      xfers_next = xfers;
    end
    if (beat_ack) begin
      burst_open_next = ~end_ack;
    end else begin
      burst_open_next = burst_open;
    end
    preempt = (state == OWNED) & (xfers_next >= CNT_W'(MAX_XFERS))
            & others_waiting & ~burst_open_next;
  end

  // Tenure counter; held at zero while idle so each new grant starts fresh
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      xfers      <= '0;
      burst_open <= 1'b0;
    end else if (state == IDLE) begin
      xfers      <= '0;
      burst_open <= 1'b0;
    end else begin
      xfers      <= xfers_next;
      burst_open <= burst_open_next;
    end
  end
`else
  // Without pre-emption a tenure ends only when the owner drops cyc
  always_comb begin
    preempt = 1'b0;
  end
`endif

  // Grant FSM: grant from idle, hold while owner cyc is high, release to idle
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= IDLE;
      grant_o <= '0;
      last    <= IDX_W'(NR_OF_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|bus.wbs_cyc_i) begin
            state   <= OWNED;
            grant_o <= pick;
            last    <= pick_idx;
          end else begin
            grant_o <= '0;
          end
        end
        OWNED: begin
          if (!owner_cyc || preempt) begin
            state   <= IDLE;
            grant_o <= '0;
          end else begin
            state   <= OWNED;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios followed by random traffic.
// Every cycle is compared against a behavioural model of the arbitration
// rules, which tracks an owner index (-1 when idle) and a last-served index.
module tb_wb_port_arbiter;
  localparam int N    = 3;
  localparam int AW   = 30;
  localparam int MAXX = 4;

  logic         wb_clk;
  logic         wb_rst;
  logic [N-1:0] grant_o;

  wb_port_arbiter_if #(.NR_OF_PORTS(N), .ADR_W(AW)) bus ();

  wb_port_arbiter #(.NR_OF_PORTS(N), .ADR_W(AW), .MAX_XFERS(MAXX)) dut (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .bus     (bus),
    .grant_o (grant_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int vectors;
  int miscompares;
  int owner;
  int last;
  int xfers;
  bit burst_open;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner      = -1;
    last       = N - 1;
    xfers      = 0;
    burst_open = 1'b0;
  endtask

  function automatic logic [N-1:0] owner_mask();
    logic [N-1:0] m;
    m = '0;
    if (owner >= 0) m[owner] = 1'b1;
    return m;
  endfunction

  // Arbitration rules applied at a rising edge, using the inputs seen there
  task automatic model_edge();
    logic [2:0] cti;
    if (wb_rst) begin
      model_reset();
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int p = (last + k) % N;
        if (bus.wbs_cyc_i[p]) begin
          owner = p; last = p; xfers = 0; burst_open = 1'b0;
          break;
        end
      end
    end else if (!bus.wbs_cyc_i[owner]) begin
      owner = -1;
    end else begin
      if (bus.wbm_ack_i) begin
        cti = bus.wbs_cti_i[owner*3 +: 3];
        if (cti == 3'b000 || cti == 3'b111) begin
          xfers++;
          burst_open = 1'b0;
        end else begin
          burst_open = 1'b1;
        end
      end
`ifdef WB_ARB_PREEMPT_EN
      if (xfers >= MAXX && (bus.wbs_cyc_i & ~owner_mask()) != '0 && !burst_open) owner = -1;
`endif
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] g;
    g = owner_mask();
    check("grant", grant_o, g);
    check("ack", bus.wbs_ack_o, bus.wbm_ack_i ? g : '0);
    check("rdata", bus.wbs_dat_o, bus.wbm_dat_i);
    if (owner >= 0) begin
      check("cyc", bus.wbm_cyc_o, bus.wbs_cyc_i[owner]);
      check("stb", bus.wbm_stb_o, bus.wbs_stb_i[owner]);
      check("we",  bus.wbm_we_o,  bus.wbs_we_i[owner]);
      check("adr", bus.wbm_adr_o, bus.wbs_adr_i[owner*AW +: AW]);
      check("wdat", bus.wbm_dat_o, bus.wbs_dat_i[owner*32 +: 32]);
      check("sel_cti_bte", {bus.wbm_sel_o, bus.wbm_cti_o, bus.wbm_bte_o},
            {bus.wbs_sel_i[owner*4 +: 4], bus.wbs_cti_i[owner*3 +: 3], bus.wbs_bte_i[owner*2 +: 2]});
    end else begin
      check("idle_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 3'b000);
      check("idle_adr", bus.wbm_adr_o, '0);
      check("idle_wdat", bus.wbm_dat_o, '0);
      check("idle_sel_cti_bte", {bus.wbm_sel_o, bus.wbm_cti_o, bus.wbm_bte_o}, '0);
    end
  endtask

  // One clock: check settled outputs, take the edge, update the model
  task automatic cycle();
    #2;
    check_outputs();
    @(posedge wb_clk);
    model_edge();
    #1;
  endtask

  task automatic set_port(input int p, input bit cyc, input bit stb, input bit we,
                          input logic [AW-1:0] adr, input logic [2:0] cti);
    bus.wbs_cyc_i[p]          = cyc;
    bus.wbs_stb_i[p]          = stb;
    bus.wbs_we_i[p]           = we;
    bus.wbs_adr_i[p*AW +: AW] = adr;
    bus.wbs_dat_i[p*32 +: 32] = $urandom;
    bus.wbs_sel_i[p*4 +: 4]   = 4'($urandom);
    bus.wbs_cti_i[p*3 +: 3]   = cti;
    bus.wbs_bte_i[p*2 +: 2]   = 2'($urandom);
  endtask

  initial begin
    logic [2:0] cti_tab [4];
    cti_tab[0] = 3'b000; cti_tab[1] = 3'b010; cti_tab[2] = 3'b111; cti_tab[3] = 3'b001;
    vectors = 0;
    miscompares = 0;
    wb_rst = 1'b1;
    bus.wbs_cyc_i = '0; bus.wbs_stb_i = '0; bus.wbs_we_i = '0;
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.wbs_sel_i = '0;
    bus.wbs_cti_i = '0; bus.wbs_bte_i = '0;
    bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = '0;
    model_reset();
    repeat (2) @(posedge wb_clk);
    #1;
    check_outputs();
    check("rst_grant", grant_o, 3'b000);
    wb_rst = 1'b0;
    cycle();

    // Single master: classic write from port 1
    set_port(1, 1'b1, 1'b1, 1'b1, 30'h100, 3'b000);
    cycle();
    check("single_grant", grant_o, 3'b010);
    check("single_adr", bus.wbm_adr_o, 30'h100);
    bus.wbm_ack_i = 1'b1;
    #1;
    check("single_ack", bus.wbs_ack_o, 3'b010);
    cycle();
    bus.wbm_ack_i = 1'b0;
    set_port(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    cycle();
    cycle();

    // Reset contention: all ports request as reset releases
    wb_rst = 1'b1;
    model_reset();
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, 1'b0, 30'(p * 16 + 4), 3'b000);
    cycle();
    wb_rst = 1'b0;
    for (int p = 0; p < N; p++) begin
      cycle();
      check("rr_grant", grant_o, 3'b001 << p);
      bus.wbm_ack_i = 1'b1;
      cycle();
      check("rr_hold", grant_o, 3'b001 << p);
      bus.wbm_ack_i = 1'b0;
      set_port(p, 1'b0, 1'b0, 1'b0, '0, 3'b000);
      cycle();
      check("rr_gap", grant_o, 3'b000);
    end

    // Burst hold: port 1 four-beat burst, port 0 requests mid-burst
    set_port(1, 1'b1, 1'b1, 1'b0, 30'h200, 3'b010);
    cycle();
    check("burst_grant", grant_o, 3'b010);
    for (int b = 0; b < 4; b++) begin
      bus.wbs_adr_i[AW +: AW] = 30'(32'h200 + b);
      bus.wbs_cti_i[3 +: 3]   = (b == 3) ? 3'b111 : 3'b010;
      if (b == 1) set_port(0, 1'b1, 1'b1, 1'b1, 30'h40, 3'b000);
      bus.wbm_ack_i = 1'b1;
      cycle();
      check("burst_hold", grant_o, 3'b010);
    end
    bus.wbm_ack_i = 1'b0;
    set_port(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    cycle();
    check("burst_gap", grant_o, 3'b000);
    cycle();
    check("burst_next", grant_o, 3'b001);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    cycle();
    cycle();

    // Read data returned to port 2
    set_port(2, 1'b1, 1'b1, 1'b0, 30'h300, 3'b000);
    cycle();
    check("rd_grant", grant_o, 3'b100);
    bus.wbm_dat_i = 32'hDEADBEEF;
    bus.wbm_ack_i = 1'b1;
    #1;
    check("rd_data", bus.wbs_dat_o, 32'hDEADBEEF);
    check("rd_ack", bus.wbs_ack_o, 3'b100);
    cycle();
    bus.wbm_ack_i = 1'b0;
    set_port(2, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    cycle();
    cycle();

    // Reset during the second beat of a port 0 burst, port 1 also waiting
    set_port(0, 1'b1, 1'b1, 1'b1, 30'h400, 3'b010);
    set_port(1, 1'b1, 1'b1, 1'b1, 30'h500, 3'b000);
    cycle();
    check("mid_grant", grant_o, 3'b001);
    bus.wbm_ack_i = 1'b1;
    cycle();
    wb_rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_grant", grant_o, 3'b000);
    check("mid_rst_cyc", bus.wbm_cyc_o, 1'b0);
    bus.wbm_ack_i = 1'b0;
    cycle();
    wb_rst = 1'b0;
    cycle();
    check("mid_regrant", grant_o, 3'b001);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    cycle();
    cycle();

`ifdef WB_ARB_PREEMPT_EN
    // Pre-emption: port 0 streams classic transfers while port 2 waits
    set_port(0, 1'b1, 1'b1, 1'b1, 30'h600, 3'b000);
    cycle();
    check("pre_grant", grant_o, 3'b001);
    set_port(2, 1'b1, 1'b1, 1'b0, 30'h700, 3'b000);
    bus.wbm_ack_i = 1'b1;
    for (int t = 0; t < MAXX; t++) begin
      check("pre_hold", grant_o, 3'b001);
      cycle();
    end
    bus.wbm_ack_i = 1'b0;
    check("pre_drop", grant_o, 3'b000);
    cycle();
    check("pre_move", grant_o, 3'b100);
    set_port(2, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    cycle();
    cycle();
    check("pre_regrant", grant_o, 3'b001);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    cycle();
    cycle();
`endif

    // Random traffic with occasional asynchronous resets
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!bus.wbs_cyc_i[p]) begin
          if ($urandom_range(2) == 0)
            set_port(p, 1'b1, 1'($urandom), 1'($urandom), 30'($urandom), cti_tab[$urandom_range(3)]);
        end else if ($urandom_range(3) == 0) begin
          set_port(p, 1'b0, 1'b0, 1'b0, '0, 3'b000);
        end else begin
          set_port(p, 1'b1, 1'($urandom), 1'($urandom), 30'($urandom), cti_tab[$urandom_range(3)]);
        end
      end
      bus.wbm_ack_i = 1'($urandom);
      bus.wbm_dat_i = $urandom;
      wb_rst = ($urandom_range(99) == 0);
      if (wb_rst) model_reset();
      cycle();
    end
    wb_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single Wishbone slave port of the SDRAM controller core (wb_sdram_ctrl_top back end) among NR_OF_PORTS Wishbone masters.
- Corresponds to the wbs0/wbs1/wbs4 requesters.
- Round-robin grant, held for a master's whole cycle (cyc_i high), so incrementing bursts are never split.
- Muxes the granted master's signals onto the controller port and routes ack/data back.

Parameters:
NR_OF_PORTS, 3, number of requesting Wishbone masters (2..8)
ADR_W, 30, word address width (byte address [31:2])
MAX_XFERS, 4, completed transfers per tenure before pre-emption (WB_ARB_PREEMPT_EN only)

Ports:
wb_clk  in  1  system Wishbone clock, all state on rising edge
wb_rst  in  1  asynchronous reset, active high
wbs_cyc_i  in  NR_OF_PORTS  per-master cyc, bit i = port i
wbs_stb_i  in  NR_OF_PORTS  per-master stb
wbs_we_i  in  NR_OF_PORTS  per-master we
wbs_adr_i  in  NR_OF_PORTS*ADR_W  packed addresses, port i at [i*ADR_W +: ADR_W]
wbs_dat_i  in  NR_OF_PORTS*32  packed write data
wbs_sel_i  in  NR_OF_PORTS*4  packed byte selects
wbs_cti_i  in  NR_OF_PORTS*3  packed cycle type
wbs_bte_i  in  NR_OF_PORTS*2  packed burst type
wbs_dat_o  out  32  read data, broadcast to all masters (= wbm_dat_i)
wbs_ack_o  out  NR_OF_PORTS  per-master ack
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  to controller
wbm_adr_o  out  ADR_W  to controller
wbm_dat_o  out  32  to controller
wbm_sel_o  out  4  to controller
wbm_cti_o  out  3  to controller
wbm_bte_o  out  2  to controller
wbm_dat_i  in  32  read data from controller
wbm_ack_i  in  1  ack from controller
grant_o  out  NR_OF_PORTS  registered one-hot grant, 0 when idle

Behaviour:
- Reset: wb_rst is asynchronous and active high.
  - Asynchronously clears grant_o to 0 and sets state to IDLE.
  - Sets last-served pointer to NR_OF_PORTS-1, so port 0 has first priority.
  - Clears the transfer counter.
  - All wbm_* control outputs and all wbs_ack_o are 0 while grant is 0.
- States:
  - IDLE: grant 0.
    - If any wbs_cyc_i is high, next edge grants the first requester found searching upward from last+1 with wrap-around; go to OWNED and set last to the granted index.
    - If none is high, stay in IDLE.
  - OWNED: grant held.
    - When the granted wbs_cyc_i is low at a clock edge, go to IDLE and clear grant.
    - Result: at least one idle cycle between tenures, so the controller always sees cyc drop.
- Latency: cyc_i rising to grant_o = 1 cycle. A master that is already granted sees no added latency.
- Mux: outputs are combinational from the grant.
  - wbm_cyc_o = |(wbs_cyc_i & grant); wbm_stb_o = |(wbs_stb_i & grant).
  - Remaining wbm_* fields are the granted slice; they are all 0 when grant is 0.
- Ack: wbs_ack_o[i] = wbm_ack_i & grant[i].
  - wbm_ack_i arriving with grant 0 is dropped.
  - Ungranted masters see ack 0 and stall.
- Simultaneous events:
  - A cyc drop and a new request in the same cycle cause the drop first (IDLE), then the new grant on the following edge.
  - A non-granted cyc toggling has no effect during OWNED.
- Bursts: cti/bte pass through untouched. Grant never changes while the granted cyc is high, except under pre-emption.
- Reset mid-burst:
  - Grant clears immediately and wbm_cyc_o falls combinationally.
  - After reset, arbitration restarts from port 0.

Optional Feature:
WB_ARB_PREEMPT_EN
- Defined:
  - A counter increments on each wbm_ack_i that has cti 000 or 111, i.e. the end of a classic transfer or burst.
  - When count ≥ MAX_XFERS, another port's cyc is high, and no burst is in progress (last ack ended one), the grant drops to IDLE at the next edge even though the owner's cyc is still high.
  - The pre-empted master is simply stalled, since no ack is given while it is not granted.
  - The counter clears on every new grant.
- Undefined: no counter; grant is released only when the owner drops cyc.

Test Plan:
- Single master: port 1 asserts cyc+stb, classic write, adr 0x100 → grant_o=3'b010 after 1 cycle; wbm_adr_o=0x100; wbm_ack_i pulse appears only on wbs_ack_o[1].
- Reset contention: all three ports request at reset release → grants in order 001, 010, 100, each tenure separated by exactly one grant=0 cycle.
- Burst hold: port 1 does a 4-beat incrementing burst (cti 010, last 111), port 0 requests mid-burst → grant stays 010 for all 4 acks; port 0 is granted 2 cycles after port 1 drops cyc.
- Read data: controller returns 0xDEADBEEF with ack to granted port 2 → wbs_dat_o=0xDEADBEEF, only wbs_ack_o[2] high.
- Reset mid-burst: wb_rst asserted during the 2nd beat of port 0 → grant_o and wbm_cyc_o go to 0 before the next clock edge; after release, port 0 is regranted first.
- With WB_ARB_PREEMPT_EN, MAX_XFERS=4: port 0 holds cyc for 6 classic transfers while port 2 requests → grant moves to port 2 after the 4th ack; port 0's stb stays unacked until it is regranted.
